// File: rtl/output_backprop_bank.sv
`default_nettype none
// ============================================================================
// Module      : output_backprop_bank
// Description : Output-layer weight bank with a sequential backward pass.
//               A pass latches err = x - final, then updates one weight per
//               cycle with delta = floor((2*err*hidden) / 2^LR_SHIFT).
//               Optional macro OUTPUT_BACKPROP_SATURATE_EN clamps each weight
//               write to the signed W_W range; otherwise writes wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module output_backprop_bank #(
  parameter int N_W      = 4,
  parameter int W_W      = 8,
  parameter int H_W      = 10,
  parameter int X_W      = 4,
  parameter int F_W      = 23,
  parameter int LR_SHIFT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [X_W-1:0]           x_i,
  input  logic [F_W-1:0]           final_i,
  input  logic [H_W-1:0]           hidden_i,
  input  logic                     zero_weight_reset_i,
  input  logic [$clog2(N_W)-1:0]   rd_idx_i,
  output logic [$clog2(N_W)-1:0]   h_idx_o,
  output logic [W_W-1:0]           w_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int IW  = $clog2(N_W);
  localparam int E_W = F_W + 2;          // signed error width
  localparam int P_W = E_W + H_W + 2;    // full width of 2*err*hidden
  localparam logic [IW-1:0] LAST_IDX = IW'(N_W - 1);
  localparam logic [IW:0]   N_W_EXT  = (IW + 1)'(N_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [E_W-1:0] err_q, err_d;
  logic signed [W_W-1:0] weight_q [N_W];
  logic signed [W_W-1:0] weight_d [N_W];

  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] delta;
  logic signed [P_W-1:0] sum;
  logic signed [W_W-1:0] wr_val;

  // Update datapath: scaled gradient step added to the addressed weight.
  always_comb begin
    prod  = P_W'(err_q) * P_W'($signed({1'b0, hidden_i}));
    // Arithmetic right shift of a signed value floors toward -infinity.
    delta = (prod <<< 1) >>> LR_SHIFT;
    sum   = delta + P_W'(weight_q[idx_q]);
`ifdef OUTPUT_BACKPROP_SATURATE_EN
    if (sum > $signed({{(P_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}})) begin
      wr_val = {1'b0, {(W_W-1){1'b1}}};
    end else if (sum < $signed({{(P_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}})) begin
      wr_val = {1'b1, {(W_W-1){1'b0}}};
    end else begin
      wr_val = sum[W_W-1:0];
    end
`else
    wr_val = sum[W_W-1:0];
`endif
  end

  // Next-state logic: pass sequencing, weight writes and synchronous clear.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    weight_d = weight_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d   = E_W'(x_i) - E_W'(final_i);
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        weight_d[idx_q] = wr_val;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Weight clear overrides everything, including a pass in flight.
    if (zero_weight_reset_i) begin
      state_d = IDLE;
      idx_d   = '0;
      for (int i = 0; i < N_W; i++) begin
        weight_d[i] = '0;
      end
    end
  end

  // State, index, error and weight registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < N_W; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      for (int i = 0; i < N_W; i++) begin
        weight_q[i] <= weight_d[i];
      end
    end
  end

  // Status outputs and combinational weight readout.
  always_comb begin
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE) && !zero_weight_reset_i;
    h_idx_o = (state_q == UPDATE) ? idx_q : '0;
    w_o     = '0;
    if ({1'b0, rd_idx_i} < N_W_EXT) begin
      w_o = weight_q[rd_idx_i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_backprop_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_backprop_bank
// Description : Self-checking bench for output_backprop_bank. Directed cases
//               plus randomized passes compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_backprop_bank;

  localparam int N_W = 4;
  localparam int LR  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  x_i = '0;
  logic [22:0] final_i = '0;
  logic [9:0]  hidden_i;
  logic        zero_weight_reset_i = 1'b0;
  logic [1:0]  rd_idx_i = '0;
  logic [1:0]  h_idx_o;
  logic [7:0]  w_o;
  logic        busy_o;
  logic        done_o;

  logic [9:0]  hid [N_W];
  logic [7:0]  mw  [N_W];

  int checks = 0;
  int failures = 0;

  output_backprop_bank dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .x_i                 (x_i),
    .final_i             (final_i),
    .hidden_i            (hidden_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .rd_idx_i            (rd_idx_i),
    .h_idx_o             (h_idx_o),
    .w_o                 (w_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Hidden activations are returned combinationally for the requested index.
  assign hidden_i = hid[h_idx_o];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Floor division by 2^LR on plain integers.
  function automatic longint floor_div(input longint p);
    longint d = longint'(1) << LR;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic logic [7:0] apply_step(input logic [7:0] w, input longint d);
    longint s;
    s = longint'($signed(w)) + d;
`ifdef OUTPUT_BACKPROP_SATURATE_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  task automatic read_all(input string tag);
    for (int i = 0; i < N_W; i++) begin
      rd_idx_i = 2'(i);
      #1;
      check(tag, w_o, mw[i]);
    end
  endtask

  task automatic clear_weights();
    zero_weight_reset_i = 1'b1;
    @(posedge clk_i); #1;
    zero_weight_reset_i = 1'b0;
    for (int i = 0; i < N_W; i++) mw[i] = '0;
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i); #1;
      if (done_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  // Full pass; optionally re-pulses start mid-pass with a different target.
  task automatic run_pass(input logic [3:0] x, input logic [22:0] f, input bit repulse);
    longint err;
    err = longint'(x) - longint'(f);
    for (int k = 0; k < N_W; k++) begin
      mw[k] = apply_step(mw[k], floor_div(2 * err * longint'(hid[k])));
    end
    x_i = x; final_i = f; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < N_W; k++) begin
      check("h_idx", h_idx_o, 64'(k));
      check("busy_upd", busy_o, 1);
      check("done_early", done_o, 0);
      if (repulse && k == 1) begin
        start_i = 1'b1; x_i = ~x; final_i = 23'd0;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    check("done_pulse", done_o, 1);
    check("h_idx_done", h_idx_o, 0);
    @(posedge clk_i); #1;
    check("done_single", done_o, 0);
    check("busy_idle", busy_o, 0);
    watch_no_done("no_extra_done", 6);
  endtask

  initial begin
    for (int i = 0; i < N_W; i++) begin hid[i] = '0; mw[i] = '0; end

    // Reset state
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hidx", h_idx_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    read_all("rst_w");

    // Basic pass: err=2, hidden=8 -> +2 on every weight
    for (int i = 0; i < N_W; i++) hid[i] = 10'd8;
    run_pass(4'd5, 23'd3, 1'b0);
    read_all("pass_basic");
    for (int i = 0; i < N_W; i++) begin
      rd_idx_i = 2'(i); #1;
      check("basic_const", w_o, 8'd2);
    end

    // Overflow case on weight 0: build 120 then add 187
    clear_weights();
    hid[0] = 10'd96; hid[1] = '0; hid[2] = '0; hid[3] = '0;
    run_pass(4'd10, 23'd0, 1'b0);
    rd_idx_i = 2'd0; #1;
    check("w0_120", w_o, 8'd120);
    hid[0] = 10'd100;
    run_pass(4'd15, 23'd0, 1'b0);
    rd_idx_i = 2'd0; #1;
`ifdef OUTPUT_BACKPROP_SATURATE_EN
    check("w0_clamp", w_o, 8'd127);
`else
    check("w0_wrap", w_o, 8'd51);
`endif
    read_all("ovf_model");

    // Negative error: -2000 / 16 -> -125
    clear_weights();
    for (int i = 0; i < N_W; i++) hid[i] = 10'd10;
    run_pass(4'd0, 23'd100, 1'b0);
    for (int i = 0; i < N_W; i++) begin
      rd_idx_i = 2'(i); #1;
      check("neg_const", w_o, 8'h83);
    end

    // Start re-pulsed during UPDATE is ignored
    run_pass(4'd7, 23'd2, 1'b1);
    read_all("repulse");

    // Clear has priority over start in IDLE
    zero_weight_reset_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    zero_weight_reset_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < N_W; i++) mw[i] = '0;
    check("clr_vs_start", busy_o, 0);
    read_all("clr_prio");

    // Clear mid-pass at index 2
    for (int i = 0; i < N_W; i++) hid[i] = 10'd50;
    x_i = 4'd9; final_i = 23'd1; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    check("hidx_at2", h_idx_o, 2);
    zero_weight_reset_i = 1'b1;
    #1 check("clr_done_sup", done_o, 0);
    @(posedge clk_i); #1;
    zero_weight_reset_i = 1'b0;
    for (int i = 0; i < N_W; i++) mw[i] = '0;
    check("clr_busy", busy_o, 0);
    check("clr_hidx", h_idx_o, 0);
    read_all("clr_mid");
    watch_no_done("clr_no_done", 8);

    // Build nonzero weights, then async reset mid-pass at index 1
    run_pass(4'd9, 23'd1, 1'b0);
    x_i = 4'd3; final_i = 23'd0; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    @(posedge clk_i); #1;
    check("hidx_at1", h_idx_o, 1);
    #1 rst_i = 1'b0;
    #1;
    for (int i = 0; i < N_W; i++) mw[i] = '0;
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_hidx", h_idx_o, 0);
    read_all("arst_w");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    watch_no_done("arst_no_done", 8);
    check("arst_idle", busy_o, 0);

    // Randomized passes against the model
    for (int n = 0; n < 24; n++) begin
      logic [3:0]  rx;
      logic [22:0] rf;
      for (int i = 0; i < N_W; i++)
        hid[i] = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      rx = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rf = 23'(rx);
        1: rf = 23'($urandom_range(0, 40));
        2: rf = 23'($urandom_range(0, 8388607));
        default: rf = 23'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 7) == 0) clear_weights();
      run_pass(rx, rf, 1'($urandom_range(0, 1)));
      read_all("rand_w");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
